// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, hardware-loop
// stack entries and the per-cycle action priority used while running.
package pc_seq_pkg;

    // Entry fields are sized for the widest supported PC/count (C_WIDTH, C_CNT_WIDTH <= 32);
    // narrower instances zero-extend on push and slice on read.
    localparam int unsigned PC_MAX_W  = 32;
    localparam int unsigned CNT_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic [PC_MAX_W-1:0]  start_pc;
        logic [PC_MAX_W-1:0]  end_pc;
        logic [CNT_MAX_W-1:0] remaining;
    } loop_entry_t;

    // Listed highest priority first; exactly one applies per enabled RUN cycle.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_LOOP,
        ACT_PUSH,
        ACT_INC
    } act_e;

endpackage

// File: rtl/loop_stack.sv
// LIFO of hardware-loop entries with push, pop, decrement-top and clear.
// Only the top entry is visible; all operations are gated by en.
module loop_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic             dec,
    input  loop_entry_t      push_entry,
    output loop_entry_t      top,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    loop_entry_t      mem_q [1 << IDX_W];
    logic [LVL_W-1:0] level_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign wr_idx  = IDX_W'(level_q);
    assign top_idx = IDX_W'(level_q - 1'b1);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign top     = mem_q[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else if (en) begin
            if (clr)                level_q <= '0;
            else if (push && !full) level_q <= level_q + 1'b1;
            else if (pop && !empty) level_q <= level_q - 1'b1;
        end
    end

    // Entry storage needs no reset: slots above level are never observed.
    always_ff @(posedge clk) begin
        if (en && !clr) begin
            if (push && !full)
                mem_q[wr_idx] <= push_entry;
            else if (dec && !pop && !empty)
                mem_q[top_idx].remaining <= mem_q[top_idx].remaining - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with nested zero-overhead hardware loops.
// IDLE -> RUN on start, RUN -> HALTED on halt, HALTED -> RUN restarts at C_START.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_CNT_WIDTH  = 16,
    parameter int                 C_LOOP_DEPTH = 4,
    parameter logic [C_WIDTH-1:0] C_START      = '0,
    localparam int                LVL_W        = $clog2(C_LOOP_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clken,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   load,
    input  logic [C_WIDTH-1:0]     load_value,
    input  logic                   loop_push,
    input  logic [C_WIDTH-1:0]     loop_end,
    input  logic [C_CNT_WIDTH-1:0] loop_count,
    output logic [C_WIDTH-1:0]     count,
    output logic                   busy,
    output logic                   done,
    output logic [LVL_W-1:0]       loop_level,
    output logic                   err
);

    state_e               state_q, state_d;
    logic [C_WIDTH-1:0]   count_q, count_d;
    logic                 err_q, err_d;
    logic                 busy_q, done_q;
    act_e                 act;

    logic                 stk_push, stk_pop, stk_dec, stk_clr;
    logic                 stk_full, stk_empty;
    loop_entry_t          push_entry, top_entry;
    logic [C_WIDTH-1:0]   top_start, top_end, count_inc;
    logic [C_CNT_WIDTH-1:0] top_rem;
    logic                 at_end, push_bad;
    logic                 unused_top_bits;

    assign top_start       = top_entry.start_pc[C_WIDTH-1:0];
    assign top_end         = top_entry.end_pc[C_WIDTH-1:0];
    assign top_rem         = top_entry.remaining[C_CNT_WIDTH-1:0];
    assign unused_top_bits = ^top_entry;

    assign count_inc = count_q + 1'b1;
    assign at_end    = !stk_empty && (count_q == top_end);
    // Equal end addresses would need two pops in one cycle, so they are rejected.
    assign push_bad  = stk_full || (loop_end <= count_q) ||
                       (!stk_empty && (loop_end == top_end));

    assign push_entry.start_pc  = PC_MAX_W'(count_inc);
    assign push_entry.end_pc    = PC_MAX_W'(loop_end);
    assign push_entry.remaining = CNT_MAX_W'(loop_count);

    always_comb begin
        act = ACT_INC;
        if (halt)           act = ACT_HOLD;
        else if (load)      act = ACT_LOAD;
        else if (at_end)    act = ACT_LOOP;
        else if (loop_push) act = ACT_PUSH;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_dec  = 1'b0;
        stk_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load)  count_d = load_value;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                case (act)
                    ACT_HOLD: state_d = ST_HALTED;
                    ACT_LOAD: count_d = load_value;
                    ACT_LOOP: begin
                        if (top_rem > C_CNT_WIDTH'(1)) begin
                            count_d = top_start;
                            stk_dec = 1'b1;
                        end else begin
                            count_d = count_inc;
                            stk_pop = 1'b1;
                        end
                        if (loop_push) err_d = 1'b1;
                    end
                    ACT_PUSH: begin
                        if (push_bad) begin
                            err_d   = 1'b1;
                            count_d = count_inc;
                        end else if (loop_count == '0) begin
                            count_d = loop_end + 1'b1;
                        end else begin
                            stk_push = 1'b1;
                            count_d  = count_inc;
                        end
                    end
                    default: count_d = count_inc;
                endcase
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = C_START;
                    err_d   = 1'b0;
                    stk_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= C_START;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clken) begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_HALTED);
        end
    end

    loop_stack #(
        .DEPTH (C_LOOP_DEPTH),
        .LVL_W (LVL_W)
    ) u_stack (
        .clk        (clk),
        .rst        (rst),
        .en         (clken),
        .clr        (stk_clr),
        .push       (stk_push),
        .pop        (stk_pop),
        .dec        (stk_dec),
        .push_entry (push_entry),
        .top        (top_entry),
        .full       (stk_full),
        .empty      (stk_empty),
        .level      (loop_level)
    );

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, loops, nesting, error pushes, halt/clken/wrap.
module tb_pc_sequencer;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst, clken, start, halt, load, loop_push;
    logic [W-1:0]  load_value, loop_end;
    logic [CW-1:0] loop_count;
    logic [W-1:0]  count;
    logic          busy, done, err;
    logic [LW-1:0] loop_level;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .C_WIDTH      (W),
        .C_CNT_WIDTH  (CW),
        .C_LOOP_DEPTH (D),
        .C_START      ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .start      (start),
        .halt       (halt),
        .load       (load),
        .load_value (load_value),
        .loop_push  (loop_push),
        .loop_end   (loop_end),
        .loop_count (loop_count),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .loop_level (loop_level),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_value = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_push(input logic [W-1:0] e, input logic [CW-1:0] n);
        loop_push = 1'b1; loop_end = e; loop_count = n;
        step();
        loop_push = 1'b0;
    endtask

    initial begin
        int exp_seq [9];
        int n5;
        rst = 1'b1; clken = 1'b1; start = 1'b0; halt = 1'b0; load = 1'b0;
        loop_push = 1'b0; load_value = '0; loop_end = '0; loop_count = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_level", loop_level, 0);

        start = 1'b1; step(); start = 1'b0;
        chk("start_count", count, 0);
        chk("start_busy", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("run_count", count, i);
        end

        // single loop: body 3..5, three passes
        do_load(2);
        chk("sl_load", count, 2);
        do_push(5, 3);
        chk("sl_first", count, 3);
        chk("sl_level1", loop_level, 1);
        exp_seq = '{4, 5, 3, 4, 5, 3, 4, 5, 6};
        for (int k = 0; k < 9; k++) begin
            step();
            chk("sl_seq", count, exp_seq[k]);
        end
        chk("sl_level0", loop_level, 0);

        // nested: outer 3..9 x2, inner 5..6 x2 pushed at PC 4
        do_load(2);
        do_push(9, 2);
        chk("nl_level", loop_level, 1);
        n5 = 0;
        loop_end = 6; loop_count = 2;
        for (int i = 0; i < 40; i++) begin
            loop_push = (count == 4);
            step();
            if (count == 5) n5++;
            if (count == 10) break;
        end
        loop_push = 1'b0;
        chk("nl_inner_runs", n5, 4);
        chk("nl_exit_count", count, 10);
        chk("nl_level0", loop_level, 0);
        chk("nl_err", err, 0);

        // push colliding with a loop-back
        do_load(2);
        do_push(3, 2);
        chk("col_setup", count, 3);
        do_push(10, 2);
        chk("col_count", count, 3);
        chk("col_err", err, 1);
        chk("col_level", loop_level, 1);
        step();
        chk("col_exit", count, 4);
        chk("col_level0", loop_level, 0);

        // asynchronous reset mid-loop
        do_load(2);
        do_push(5, 3);
        chk("ar_level_pre", loop_level, 1);
        rst = 1'b1; #1;
        chk("ar_count", count, 0);
        chk("ar_level", loop_level, 0);
        chk("ar_err", err, 0);
        chk("ar_busy", busy, 0);
        step();
        rst = 1'b0;
        step();

        // IDLE: load honoured, push ignored
        do_load(9);
        chk("idle_load", count, 9);
        chk("idle_busy", busy, 0);
        do_push(20, 2);
        chk("idle_push_count", count, 9);
        chk("idle_push_level", loop_level, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("idle_start_count", count, 9);
        do_load(0);

        // fill the stack, then push on full
        for (int i = 0; i < 4; i++) do_push(W'(100 - i), 2);
        chk("full_level", loop_level, 4);
        chk("full_count", count, 4);
        chk("full_err0", err, 0);
        do_load(2);
        do_push(50, 2);
        chk("full_next", count, 3);
        chk("full_err", err, 1);
        chk("full_level_kept", loop_level, 4);

        halt = 1'b1; step(); halt = 1'b0;
        chk("h_done", done, 1);
        chk("h_busy", busy, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("rs_count", count, 0);
        chk("rs_err", err, 0);
        chk("rs_level", loop_level, 0);
        chk("rs_done", done, 0);

        do_load(2);
        do_push(2, 3);
        chk("le_next", count, 3);
        chk("le_err", err, 1);
        chk("le_level", loop_level, 0);
        do_load(2);
        do_push(7, 0);
        chk("zc_next", count, 8);
        chk("zc_level", loop_level, 0);
        chk("zc_err", err, 1);

        // halt mid-loop freezes the PC
        do_load(2);
        do_push(5, 3);
        step();
        chk("hm_pre", count, 4);
        halt = 1'b1; step(); halt = 1'b0;
        chk("hm_done", done, 1);
        chk("hm_count", count, 4);
        step();
        do_push(9, 2);
        chk("hm_frozen", count, 4);
        chk("hm_level", loop_level, 1);
        start = 1'b1; step(); start = 1'b0;
        chk("hm_restart", count, 0);
        chk("hm_restart_lvl", loop_level, 0);

        // clock enable low freezes everything
        step();
        chk("ce_pre", count, 1);
        clken = 1'b0; load = 1'b1; load_value = 77;
        step(); step(); step();
        chk("ce_count", count, 1);
        chk("ce_busy", busy, 1);
        clken = 1'b1; load = 1'b0;

        // wrap at max PC
        do_load(255);
        chk("wrap_pre", count, 255);
        step();
        chk("wrap", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter C_WIDTH, default 8: program-counter width in bits.
REQ-002 SHALL have parameter C_CNT_WIDTH, default 16: loop iteration-count width.
REQ-003 SHALL have parameter C_LOOP_DEPTH, default 4: maximum nested hardware loops, at least 1.
REQ-004 SHALL have parameter C_START, default 0: restart address, C_WIDTH bits.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port clken  in  1  clock enable; when 0, all state (PC, FSM, stack, err) holds.
REQ-008 SHALL have port start  in  1  leave IDLE or HALTED into RUN.
REQ-009 SHALL have port halt  in  1  stop sequencing.
REQ-010 SHALL have port load  in  1  absolute jump request.
REQ-011 SHALL have port load_value  in  C_WIDTH  jump target.
REQ-012 SHALL have port loop_push  in  1  current PC is a loop-setup instruction.
REQ-013 SHALL have port loop_end  in  C_WIDTH  last body address (inclusive).
REQ-014 SHALL have port loop_count  in  C_CNT_WIDTH  iteration count.
REQ-015 SHALL have port count  out  C_WIDTH  current PC.
REQ-016 SHALL have port busy  out  1  high in RUN.
REQ-017 SHALL have port done  out  1  high in HALTED.
REQ-018 SHALL have port loop_level  out  $clog2(C_LOOP_DEPTH+1)  stack occupancy.
REQ-019 SHALL have port err  out  1  sticky error flag.

Function
REQ-020 SHALL use FSM states IDLE, RUN and HALTED.
REQ-021 SHALL transition IDLE->RUN on start; RUN->HALTED on halt; HALTED->RUN on start, with count=C_START, stack empty and err cleared.
REQ-022 In IDLE, load SHALL set count=load_value; all other requests SHALL be ignored.
REQ-023 In RUN, each enabled cycle SHALL apply exactly one action, in priority order: halt (hold), load, loop-back, loop_push, increment.
REQ-024 load in RUN SHALL set count=load_value and leave the stack untouched.
REQ-025 Loop-back SHALL occur when the stack is non-empty and count==top.end: if top.remaining>1, count=top.start and remaining decrements; otherwise the top is popped and count=count+1.
REQ-026 Only one level SHALL pop per cycle.
REQ-027 A valid loop_push SHALL push {start=count+1, end=loop_end, remaining=loop_count} and set count=count+1.
REQ-028 loop_push with loop_count==0 SHALL skip the body: no push, count=loop_end+1.
REQ-029 Each of the following SHALL cause loop_push to be ignored, set err, and apply count=count+1: stack full; loop_end<=count; loop_end equal to the current top.end.
REQ-030 loop_push coinciding with a loop-back SHALL be ignored and SHALL set err.
REQ-031 Increment SHALL wrap modulo 2^C_WIDTH (max->0), as SHALL loop_end+1 and count+1.
REQ-032 In HALTED, count SHALL hold and load and loop_push SHALL be ignored.
REQ-033 err SHALL be sticky until rst or start-from-HALTED.
REQ-034 Outputs SHALL be registered, and a change SHALL be visible the cycle after the triggering edge.

Reset
REQ-035 While rst=1 (asynchronous) the block SHALL force: state=IDLE, count=C_START, stack empty, loop_level=0, busy=0, done=0, err=0.
REQ-036 rst asserted mid-loop SHALL discard all stack entries.

Structure
REQ-037 Package pc_seq_pkg SHALL hold the FSM state enum, the loop-entry struct typedef {start, end, remaining}, and the action-priority encoding.
REQ-038 Sub-module loop_stack SHALL be a parameterised LIFO of loop entries with push, pop, decrement-top, full/empty and level ports, with the same clk/rst.

Verification
REQ-039 Reset and start: C_START=0; rst pulse, then start -> count shows 0,1,2,3 on successive cycles; busy=1.
REQ-040 Single loop: at PC=2, push end=5, count=3 -> sequence 3,4,5,3,4,5,3,4,5,6; loop_level 1 then 0.
REQ-041 Nested loops: outer end=9 x2, inner end=6 x2 at PC=4 -> inner body runs 4 times total; err=0.
REQ-042 Error cases: push on full stack; push with loop_end<=PC; push with zero count at PC=2, end=7 -> err=1 and next PC=3,3,8 respectively.
REQ-043 Control: halt mid-loop -> done=1 and count frozen; clken=0 for 3 cycles -> no change; at count=255 (C_WIDTH=8) increment -> 0.
